delay_seq_gen: RTL and testbench
================================

DELAY_SEQ_GEN -- requirements
Module: delay_seq_gen

Interface
REQ-001 Parameter DELAY, default 2, cycles from a_out pulse to b_out pulse; legal range 1..15.
REQ-002 Parameter CNT_W, default 8, width of iter and pair_cnt.
REQ-003 clk  input  1  single clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  request a burst; sampled only in IDLE.
REQ-006 iter  input  CNT_W  number of a->b pairs in the burst; sampled with start.
REQ-007 gap  input  4  idle cycles between a b pulse and the next a pulse; sampled with start.
REQ-008 inject_err  input  1  when 1 with start, the last pair of the burst is deliberately malformed; sampled with start.
REQ-009 a_out  output  1  antecedent pulse, registered.
REQ-010 b_out  output  1  consequent pulse, registered.
REQ-011 busy  output  1  high from the start accept until done.
REQ-012 done  output  1  one-cycle pulse at burst end.
REQ-013 pair_cnt  output  CNT_W  pairs completed in the current or last burst.

Function
REQ-014 The FSM shall have the states IDLE, A, WAIT, B and GAP; all outputs shall be registered.
REQ-015 IDLE: on start=1 at edge E0 with iter!=0, latch iter/gap/inject_err, clear pair_cnt, go to A; a_out=1 and busy=1 after E0.
REQ-016 IDLE with start=1 and iter==0: no a_out/b_out; done=1 for one cycle after E0; busy stays 0; pair_cnt cleared to 0.
REQ-017 A lasts exactly one cycle; a_out is a one-cycle pulse.
REQ-018 WAIT: counter such that b_out=1 after edge E0+DELAY for a normal pair, i.e. a checker sampling a at edge E0+1 sees b at edge E0+1+DELAY.
REQ-019 Pair malformed by inject_err (last pair only): b_out after edge E0+DELAY+1 instead of E0+DELAY; all earlier pairs shall be normal.
REQ-020 B lasts one cycle; pair_cnt increments by 1 (wrapping modulo 2^CNT_W) in the same cycle b_out=1.
REQ-021 After B with pairs remaining: GAP for gap cycles (0 = none), then A; next a_out rises gap+1 cycles after b_out rises; a_out and b_out shall never be 1 together.
REQ-022 After B of the last pair: busy=0 and done=1 together for one cycle, return to IDLE.
REQ-023 start while busy=1 shall be ignored with no effect on the latched parameters or the sequence.
REQ-024 Input changes on iter/gap/inject_err while busy shall not affect the running burst.
REQ-025 start in the done cycle shall be accepted (back-to-back bursts); its a_out appears one cycle after that edge.

Reset
REQ-026 rst=1 at an edge shall force IDLE and set a_out=0, b_out=0, busy=0, done=0, pair_cnt=0 after that edge, from any state.
REQ-027 rst has priority over start; a burst interrupted by rst shall not resume and shall not pulse done.

Verification
REQ-028 DELAY=2, start with iter=1, gap=0 at E0 -> a_out=1 in cycle E0..E1, b_out=1 in cycle E2..E3, done=1 in cycle E3..E4, pair_cnt=1.
REQ-029 DELAY=2, iter=3, gap=2 -> a pulses after E0, E5 and E10; b pulses after E2, E7 and E12; done after E13; pair_cnt=3; a and b never overlap.
REQ-030 DELAY=2, iter=2, gap=0, inject_err=1 -> pair 1 has b 2 cycles after a; pair 2 has b 3 cycles after a; an a ##2 b property passes once and fails once.
REQ-031 iter=0 -> done one cycle, no a/b, busy=0, pair_cnt=0.
REQ-032 rst=1 during WAIT of pair 2 of 4 -> next cycle all outputs 0, no b, no done; fresh start runs a full normal burst.
REQ-033 start pulsed during busy and again in the done cycle -> first ignored, second begins a new burst one cycle later, pair_cnt restarts from 0.

Source files
------------

// File: rtl/delay_seq_gen.sv
// Antecedent/consequent pulse-pair generator: emits bursts of a_out -> b_out pairs
// with a fixed a-to-b distance, a programmable gap between pairs and an optional malformed last pair.
module delay_seq_gen #(
    parameter int DELAY = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] iter,
    input  logic [3:0]       gap,
    input  logic             inject_err,
    output logic             a_out,
    output logic             b_out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pair_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        A,
        WAIT,
        B,
        GAP
    } state_t;

    // Cycles spent in WAIT for a normal pair; A itself accounts for one of the DELAY cycles.
    localparam logic [3:0] WAIT_BASE = 4'(DELAY - 1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] remain_reg, remain_next;
    logic [3:0]       gap_len_reg, gap_len_next;
    logic             err_reg, err_next;
    logic [3:0]       wait_cnt_reg, wait_cnt_next;
    logic [3:0]       gap_cnt_reg, gap_cnt_next;
    logic [CNT_W-1:0] pair_cnt_reg, pair_cnt_next;
    logic             a_out_reg, b_out_reg, busy_reg, done_reg;
    logic             done_next;
    logic [3:0]       wait_len;

    always_comb begin
        state_next    = state_reg;
        remain_next   = remain_reg;
        gap_len_next  = gap_len_reg;
        err_next      = err_reg;
        wait_cnt_next = wait_cnt_reg;
        gap_cnt_next  = gap_cnt_reg;
        pair_cnt_next = pair_cnt_reg;
        done_next     = 1'b0;
        // The malformed pair stretches its WAIT by a single cycle.
        wait_len      = WAIT_BASE + {3'b000, (err_reg && remain_reg == CNT_W'(1))};

        case (state_reg)
            IDLE: begin
                if (start) begin
                    gap_len_next  = gap;
                    err_next      = inject_err;
                    remain_next   = iter;
                    pair_cnt_next = '0;
                    if (iter != '0) begin
                        state_next = A;
                    end else begin
                        done_next = 1'b1;
                    end
                end
            end
            A: begin
                if (wait_len == 4'd0) begin
                    state_next    = B;
                    pair_cnt_next = pair_cnt_reg + CNT_W'(1);
                end else begin
                    state_next    = WAIT;
                    wait_cnt_next = wait_len - 4'd1;
                end
            end
            WAIT: begin
                if (wait_cnt_reg == 4'd0) begin
                    state_next    = B;
                    pair_cnt_next = pair_cnt_reg + CNT_W'(1);
                end else begin
                    wait_cnt_next = wait_cnt_reg - 4'd1;
                end
            end
            B: begin
                if (remain_reg == CNT_W'(1)) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end else begin
                    remain_next = remain_reg - CNT_W'(1);
                    if (gap_len_reg == 4'd0) begin
                        state_next = A;
                    end else begin
                        state_next   = GAP;
                        gap_cnt_next = gap_len_reg - 4'd1;
                    end
                end
            end
            GAP: begin
                if (gap_cnt_reg == 4'd0) begin
                    state_next = A;
                end else begin
                    gap_cnt_next = gap_cnt_reg - 4'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs are registered copies of the upcoming state so they align with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            remain_reg   <= '0;
            gap_len_reg  <= 4'd0;
            err_reg      <= 1'b0;
            wait_cnt_reg <= 4'd0;
            gap_cnt_reg  <= 4'd0;
            pair_cnt_reg <= '0;
            a_out_reg    <= 1'b0;
            b_out_reg    <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            remain_reg   <= remain_next;
            gap_len_reg  <= gap_len_next;
            err_reg      <= err_next;
            wait_cnt_reg <= wait_cnt_next;
            gap_cnt_reg  <= gap_cnt_next;
            pair_cnt_reg <= pair_cnt_next;
            a_out_reg    <= (state_next == A);
            b_out_reg    <= (state_next == B);
            busy_reg     <= (state_next != IDLE);
            done_reg     <= done_next;
        end
    end

    assign a_out    = a_out_reg;
    assign b_out    = b_out_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;
    assign pair_cnt = pair_cnt_reg;

endmodule

// File: tb/tb_delay_seq_gen.sv
// Directed bench for delay_seq_gen (DELAY=2): captures per-cycle traces of the outputs
// and compares them with hand-derived bit patterns.
module tb_delay_seq_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] iter;
    logic [3:0] gap;
    logic       inject_err;
    logic       a_out, b_out, busy, done;
    logic [7:0] pair_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] a_tr, b_tr, d_tr, y_tr;
    logic [7:0]  pc0;
    int          pass_cnt, fail_cnt;

    delay_seq_gen #(.DELAY(2), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .iter       (iter),
        .gap        (gap),
        .inject_err (inject_err),
        .a_out      (a_out),
        .b_out      (b_out),
        .busy       (busy),
        .done       (done),
        .pair_cnt   (pair_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bit i of each trace holds the output value just after the i-th captured edge.
    task automatic capture(input int n);
        a_tr = '0; b_tr = '0; d_tr = '0; y_tr = '0;
        for (int i = 0; i < n; i++) begin
            tick();
            start = 1'b0;
            a_tr[i] = a_out;
            b_tr[i] = b_out;
            d_tr[i] = done;
            y_tr[i] = busy;
            if (i == 0) pc0 = pair_cnt;
        end
    endtask

    task automatic launch(input logic [7:0] it, input logic [3:0] gp, input logic er);
        start = 1'b1; iter = it; gap = gp; inject_err = er;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; iter = 8'd0; gap = 4'd0; inject_err = 1'b0;
        tick(); tick();
        check("reset_outputs", {a_out, b_out, busy, done, pair_cnt}, 64'h0);
        rst = 1'b0;
        tick();

        // Single pair, gap 0
        launch(8'd1, 4'd0, 1'b0);
        capture(6);
        check("single_a", a_tr, 64'h01);
        check("single_b", b_tr, 64'h04);
        check("single_done", d_tr, 64'h08);
        check("single_busy", y_tr, 64'h07);
        check("single_pair_cnt", pair_cnt, 64'd1);

        // Three pairs, gap 2
        launch(8'd3, 4'd2, 1'b0);
        capture(16);
        check("burst3_a", a_tr, 64'h0421);
        check("burst3_b", b_tr, 64'h1084);
        check("burst3_done", d_tr, 64'h2000);
        check("burst3_busy", y_tr, 64'h1FFF);
        check("burst3_overlap", a_tr & b_tr, 64'h0);
        check("burst3_pair_cnt", pair_cnt, 64'd3);

        // Two pairs with a malformed last pair
        launch(8'd2, 4'd0, 1'b1);
        capture(10);
        check("err_a", a_tr, 64'h09);
        check("err_b", b_tr, 64'h44);
        check("err_done", d_tr, 64'h80);
        pass_cnt = 0; fail_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (a_tr[i]) begin
                if (b_tr[i+2]) pass_cnt++;
                else fail_cnt++;
            end
        end
        check("err_prop_pass", pass_cnt, 64'd1);
        check("err_prop_fail", fail_cnt, 64'd1);

        // Zero-length burst
        launch(8'd0, 4'd3, 1'b0);
        capture(3);
        check("zero_ab", a_tr | b_tr, 64'h0);
        check("zero_done", d_tr, 64'h1);
        check("zero_busy", y_tr, 64'h0);
        check("zero_pair_cnt", pair_cnt, 64'd0);

        // Reset during WAIT of pair 2 of 4
        launch(8'd4, 4'd1, 1'b0);
        capture(6);
        check("rst_pre_a", a_tr, 64'h11);
        check("rst_pre_b", b_tr, 64'h04);
        rst = 1'b1;
        tick();
        check("rst_outputs", {a_out, b_out, busy, done, pair_cnt}, 64'h0);
        rst = 1'b0;
        capture(6);
        check("rst_quiet", a_tr | b_tr | d_tr | y_tr, 64'h0);
        launch(8'd2, 4'd0, 1'b0);
        capture(8);
        check("rst_fresh_a", a_tr, 64'h09);
        check("rst_fresh_b", b_tr, 64'h24);
        check("rst_fresh_done", d_tr, 64'h40);
        check("rst_fresh_pair_cnt", pair_cnt, 64'd2);

        // Start while busy is ignored; start in the done cycle is accepted
        launch(8'd2, 4'd0, 1'b0);
        tick();
        launch(8'd5, 4'd3, 1'b1);
        capture(6);
        check("busy_start_a", a_tr, 64'h04);
        check("busy_start_b", b_tr, 64'h12);
        check("busy_start_done", d_tr, 64'h20);
        check("busy_start_pair_cnt", pair_cnt, 64'd2);
        launch(8'd1, 4'd0, 1'b0);
        capture(5);
        check("b2b_a", a_tr, 64'h01);
        check("b2b_b", b_tr, 64'h04);
        check("b2b_done", d_tr, 64'h08);
        check("b2b_pair_cnt_restart", pc0, 64'd0);
        check("b2b_pair_cnt", pair_cnt, 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
